// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard.
//   T_W        width of the Tnew/Tuse fields (values 0..3)
//   FWD_*      forwarding mux select codes (D side: RF/M/E, E side: RF/M/W)
//   TNEW_*     Tnew of the common instruction classes
//   slot_t     one shadow-pipeline entry {valid, dst, tnew, rs, rt}
package hazard_pkg;

    localparam int T_W   = 2;
    localparam int REG_W = 5;

    typedef logic [T_W-1:0]   tval_t;
    typedef logic [REG_W-1:0] reg_t;

    // E-side W select shares the code of D-side E select, so these are
    // plain constants rather than an enum.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_E  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd2;

    localparam tval_t TNEW_LINK = tval_t'(0);
    localparam tval_t TNEW_ALU  = tval_t'(1);
    localparam tval_t TNEW_LOAD = tval_t'(2);

    typedef struct packed {
        logic  valid;
        reg_t  dst;
        tval_t tnew;
        reg_t  rs;
        reg_t  rt;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // A slot produces a register value only when it is a real instruction
    // with a non-zero destination; $0 therefore never matches anything.
    function automatic logic slot_writes(input slot_t s, input reg_t r);
        return s.valid && (s.dst != '0) && (s.dst == r);
    endfunction

    // Tnew counts down by one per stage and stops at zero.
    function automatic tval_t tnew_dec(input tval_t t);
        return (t == '0) ? '0 : tval_t'(t - 1'b1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Handshake bundle between the datapath and the hazard scoreboard.
//   master : datapath side, drives the D-stage descriptor, receives stall,
//            forwarding selects, RF write control and the stall counter
//   slave  : scoreboard side
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             d_valid;
    reg_t             d_rs;
    reg_t             d_rt;
    logic             d_use_rs;
    logic             d_use_rt;
    tval_t            d_tuse_rs;
    tval_t            d_tuse_rt;
    reg_t             d_dst;
    tval_t            d_tnew;

    logic             stall;
    logic [1:0]       fwd_d_rs;
    logic [1:0]       fwd_d_rt;
    logic [1:0]       fwd_e_rs;
    logic [1:0]       fwd_e_rt;
    logic             rf_we;
    reg_t             rf_a3;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_valid, d_rs, d_rt, d_use_rs, d_use_rt,
               d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt,
               rf_we, rf_a3, stall_cnt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt,
               d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt,
               rf_we, rf_a3, stall_cnt
    );

endinterface

// File: rtl/hz_slot.sv
// One shadow-pipeline slot of the hazard scoreboard.
//   clk, reset : clock, synchronous active-high reset
//   bubble     : load an empty slot instead of slot_in
//   slot_in    : entry arriving from the previous stage
//   slot_q     : registered entry
//   AGE        : decrement tnew as the entry moves in (0 for the E slot,
//                whose tnew is counted from entry into E)
module hz_slot
    import hazard_pkg::*;
#(
    parameter bit AGE = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  bubble,
    input  slot_t slot_in,
    output slot_t slot_q
);

    slot_t slot_d;

    always_comb begin
        // NOTE: assign a default first so no path leaves slot_d unassigned (no latch).
        slot_d = slot_in;
        if (AGE) begin
            slot_d.tnew = tnew_dec(slot_in.tnew);
        end
        if (bubble) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for registered state avoid update-order races.
        if (reset) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage F/D/E/M/W pipeline.
// Tracks {valid, dst, tnew, rs, rt} for E, M and W and derives:
//   clk, reset  : clock, synchronous active-high reset
//   hz.d_*      : D-stage descriptor (sources, their Tuse, destination, Tnew)
//   hz.stall    : freeze PC and F/D, bubble into E (combinational)
//   hz.fwd_d_*  : D operand select 0=RF 1=M 2=E (combinational)
//   hz.fwd_e_*  : E operand select 0=D/E 1=M 2=W (combinational)
//   hz.rf_we/a3 : RF write port control from the W slot (registered)
//   hz.stall_cnt: saturating count of stalled cycles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);

    slot_t            e_in;
    slot_t            e_q;
    slot_t            m_q;
    slot_t            w_q;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q;

    // Nearest producer decides: if it is still too young for this source's
    // Tuse, D must wait. W is never consulted because the RF bypasses it.
    function automatic logic src_hazard(input logic  used,
                                        input reg_t  r,
                                        input tval_t tuse,
                                        input slot_t e,
                                        input slot_t m);
        logic hit;
        hit = 1'b0;
        if (used) begin
            if (slot_writes(e, r)) begin
                hit = (e.tnew > tuse);
            end else if (slot_writes(m, r)) begin
                hit = (m.tnew > tuse);
            end
        end
        return hit;
    endfunction

    // Nearest producer wins; it forwards only once its result exists.
    // A younger producer that is not ready masks an older ready one.
    function automatic logic [1:0] fwd_sel(input reg_t       r,
                                           input slot_t      near,
                                           input slot_t      far,
                                           input logic [1:0] near_code,
                                           input logic [1:0] far_code);
        logic [1:0] sel;
        sel = FWD_RF;
        if (slot_writes(near, r)) begin
            sel = (near.tnew == '0) ? near_code : FWD_RF;
        end else if (slot_writes(far, r)) begin
            sel = (far.tnew == '0) ? far_code : FWD_RF;
        end
        return sel;
    endfunction

    assign e_in = '{valid: hz.d_valid, dst: hz.d_dst, tnew: hz.d_tnew,
                    rs: hz.d_rs, rt: hz.d_rt};

    // A single stall covers both sources; a D bubble reads nothing.
    assign stall = hz.d_valid &&
                   (src_hazard(hz.d_use_rs, hz.d_rs, hz.d_tuse_rs, e_q, m_q) ||
                    src_hazard(hz.d_use_rt, hz.d_rt, hz.d_tuse_rt, e_q, m_q));

    hz_slot #(.AGE(1'b0)) u_slot_e (
        .clk     (clk),
        .reset   (reset),
        .bubble  (stall),
        .slot_in (e_in),
        .slot_q  (e_q)
    );

    hz_slot #(.AGE(1'b1)) u_slot_m (
        .clk     (clk),
        .reset   (reset),
        .bubble  (1'b0),
        .slot_in (e_q),
        .slot_q  (m_q)
    );

    hz_slot #(.AGE(1'b1)) u_slot_w (
        .clk     (clk),
        .reset   (reset),
        .bubble  (1'b0),
        .slot_in (m_q),
        .slot_q  (w_q)
    );

    // W's source fields have no consumer; every slot keeps the same shape.
    logic unused_w_src;
    assign unused_w_src = ^{w_q.rs, w_q.rt};

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign hz.stall     = stall;
    assign hz.fwd_d_rs  = fwd_sel(hz.d_rs, e_q, m_q, FWD_E, FWD_M);
    assign hz.fwd_d_rt  = fwd_sel(hz.d_rt, e_q, m_q, FWD_E, FWD_M);
    assign hz.fwd_e_rs  = fwd_sel(e_q.rs, m_q, w_q, FWD_M, FWD_W);
    assign hz.fwd_e_rt  = fwd_sel(e_q.rt, m_q, w_q, FWD_M, FWD_W);
    assign hz.rf_we     = w_q.valid && (w_q.dst != '0);
    assign hz.rf_a3     = w_q.dst;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios
// followed by a randomized run against a timestamp-based reference model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(CNT_W)) hz();

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- stimulus helpers ----------------
    task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] dst, input logic [1:0] tnew);
        hz.d_valid   = v;
        hz.d_rs      = rs;
        hz.d_rt      = rt;
        hz.d_use_rs  = urs;
        hz.d_use_rt  = urt;
        hz.d_tuse_rs = trs;
        hz.d_tuse_rt = trt;
        hz.d_dst     = dst;
        hz.d_tnew    = tnew;
    endtask

    task automatic nop();
        set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", hz.stall); end
        n_checks++; if ({hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt} !== 8'h00) begin
            n_fail++; $display("FAIL reset_fwd: got %h want 00", {hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt}); end
        n_checks++; if (hz.rf_we !== 1'b0 || hz.rf_a3 !== 5'd0) begin
            n_fail++; $display("FAIL reset_rf: got we=%0d a3=%0d want 0/0", hz.rf_we, hz.rf_a3); end
        n_checks++; if (hz.stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", hz.stall_cnt); end
    endtask

    // lw $8 then addu $9,$8,$8
    task automatic test_load_use();
        do_reset();
        set_d(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd8, TNEW_LOAD);
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall: got %0d want 0", hz.stall); end
        next_cycle();
        set_d(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 2'd1, 2'd1, 5'd9, TNEW_ALU);
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0d want 1", hz.stall); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %0d want 0", hz.stall); end
        n_checks++; if (hz.fwd_d_rs !== FWD_RF) begin n_fail++; $display("FAIL lu_fwd_d_rs: got %0d want 0", hz.fwd_d_rs); end
        next_cycle();
        nop();
        @(negedge clk);
        n_checks++; if (hz.fwd_e_rs !== 2'd2 || hz.fwd_e_rt !== 2'd2) begin
            n_fail++; $display("FAIL lu_fwd_e: got rs=%0d rt=%0d want 2/2", hz.fwd_e_rs, hz.fwd_e_rt); end
        n_checks++; if (hz.rf_we !== 1'b1 || hz.rf_a3 !== 5'd8) begin
            n_fail++; $display("FAIL lu_rf: got we=%0d a3=%0d want 1/8", hz.rf_we, hz.rf_a3); end
        n_checks++; if (hz.stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", hz.stall_cnt); end
    endtask

    // addu $8 then beq $8,$0
    task automatic test_alu_branch();
        do_reset();
        set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 2'd1, 2'd1, 5'd8, TNEW_ALU);
        next_cycle();
        set_d(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, TNEW_LINK);
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b1) begin n_fail++; $display("FAIL br_stall: got %0d want 1", hz.stall); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL br_release: got %0d want 0", hz.stall); end
        n_checks++; if (hz.fwd_d_rs !== 2'd1 || hz.fwd_d_rt !== 2'd0) begin
            n_fail++; $display("FAIL br_fwd_d: got rs=%0d rt=%0d want 1/0", hz.fwd_d_rs, hz.fwd_d_rt); end
        n_checks++; if (hz.stall_cnt !== 32'd1) begin n_fail++; $display("FAIL br_cnt: got %0d want 1", hz.stall_cnt); end
    endtask

    // jal then jr $31
    task automatic test_jal_jr();
        do_reset();
        set_d(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd31, TNEW_LINK);
        next_cycle();
        set_d(1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL jr_stall: got %0d want 0", hz.stall); end
        n_checks++; if (hz.fwd_d_rs !== 2'd2) begin n_fail++; $display("FAIL jr_fwd_d_rs: got %0d want 2", hz.fwd_d_rs); end
    endtask

    // addu $0,$1,$2 then a reader of $0
    task automatic test_reg_zero();
        do_reset();
        set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 2'd1, 2'd1, 5'd0, TNEW_ALU);
        next_cycle();
        set_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd3, TNEW_ALU);
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL z_stall: got %0d want 0", hz.stall); end
        n_checks++; if (hz.fwd_d_rs !== 2'd0 || hz.fwd_d_rt !== 2'd0) begin
            n_fail++; $display("FAIL z_fwd_d: got rs=%0d rt=%0d want 0/0", hz.fwd_d_rs, hz.fwd_d_rt); end
        next_cycle();
        nop();
        @(negedge clk);
        n_checks++; if (hz.fwd_e_rs !== 2'd0 || hz.fwd_e_rt !== 2'd0) begin
            n_fail++; $display("FAIL z_fwd_e: got rs=%0d rt=%0d want 0/0", hz.fwd_e_rs, hz.fwd_e_rt); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (hz.rf_we !== 1'b0) begin n_fail++; $display("FAIL z_rf_we: got %0d want 0", hz.rf_we); end
    endtask

    // addu $5, subu $5, then reader of $5: nearest producer must win
    task automatic test_back_to_back();
        do_reset();
        set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 2'd1, 2'd1, 5'd5, TNEW_ALU);
        next_cycle();
        set_d(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 2'd1, 2'd1, 5'd5, TNEW_ALU);
        next_cycle();
        set_d(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 2'd1, 2'd1, 5'd6, TNEW_ALU);
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %0d want 0", hz.stall); end
        next_cycle();
        nop();
        @(negedge clk);
        n_checks++; if (hz.fwd_e_rs !== 2'd1 || hz.fwd_e_rt !== 2'd1) begin
            n_fail++; $display("FAIL b2b_fwd_e: got rs=%0d rt=%0d want 1/1", hz.fwd_e_rs, hz.fwd_e_rt); end
        n_checks++; if (hz.rf_we !== 1'b1 || hz.rf_a3 !== 5'd5) begin
            n_fail++; $display("FAIL b2b_rf: got we=%0d a3=%0d want 1/5", hz.rf_we, hz.rf_a3); end
    endtask

    // Reset raised while the load-use stall is active
    task automatic test_reset_in_stall();
        do_reset();
        set_d(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd8, TNEW_LOAD);
        next_cycle();
        set_d(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 2'd1, 2'd1, 5'd9, TNEW_ALU);
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b1) begin n_fail++; $display("FAIL rs_pre_stall: got %0d want 1", hz.stall); end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL rs_stall: got %0d want 0", hz.stall); end
        n_checks++; if (hz.rf_we !== 1'b0) begin n_fail++; $display("FAIL rs_rf_we: got %0d want 0", hz.rf_we); end
        n_checks++; if (hz.stall_cnt !== '0) begin n_fail++; $display("FAIL rs_cnt: got %0d want 0", hz.stall_cnt); end
        nop();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            n_checks++; if (hz.rf_we !== 1'b0) begin n_fail++; $display("FAIL rs_drain%0d: got rf_we=%0d want 0", i, hz.rf_we); end
        end
    endtask

    // ---------------- reference model ----------------
    // Each in-flight instruction remembers the absolute cycle at which its
    // result exists; remaining latency is derived from the current cycle.
    typedef struct {
        bit valid;
        int dst;
        int ready;
        int rs;
        int rt;
    } mslot_t;

    mslot_t      pipe [3];   // 0 = E, 1 = M, 2 = W
    int          now;
    int unsigned m_cnt;

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{valid: 0, dst: 0, ready: 0, rs: 0, rt: 0};
        now   = 0;
        m_cnt = 0;
    endfunction

    function automatic int remaining(input int i);
        return (pipe[i].ready > now) ? pipe[i].ready - now : 0;
    endfunction

    function automatic bit produces(input int i, input int r);
        return pipe[i].valid && r != 0 && pipe[i].dst == r;
    endfunction

    function automatic bit m_src_stall(input bit used, input int r, input int tuse);
        for (int i = 0; i < 2; i++)
            if (used && produces(i, r)) return remaining(i) > tuse;
        return 0;
    endfunction

    // stage_lo/stage_lo+1 are searched youngest first; codes per stage.
    function automatic int m_fwd(input int r, input int stage_lo, input int code_lo, input int code_hi);
        for (int i = stage_lo; i < stage_lo + 2; i++)
            if (produces(i, r)) return (remaining(i) == 0) ? ((i == stage_lo) ? code_lo : code_hi) : 0;
        return 0;
    endfunction

    task automatic test_random();
        bit v = 0, urs = 0, urt = 0, hold = 0, rst_now;
        int rs = 0, rt = 0, trs = 0, trt = 0, dst = 0, tnew = 0;
        bit exp_stall;
        int exp_dr, exp_dt, exp_er, exp_et;
        do_reset();
        model_clear();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!hold) begin
                v    = ($urandom_range(0, 9) != 0);
                rs   = $urandom_range(0, 7);
                rt   = $urandom_range(0, 7);
                urs  = $urandom_range(0, 1);
                urt  = $urandom_range(0, 1);
                trs  = $urandom_range(0, 2);
                trt  = $urandom_range(0, 2);
                dst  = $urandom_range(0, 7);
                tnew = $urandom_range(0, 3);
            end
            set_d(v, 5'(rs), 5'(rt), urs, urt, 2'(trs), 2'(trt), 5'(dst), 2'(tnew));
            rst_now = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            exp_stall = v && (m_src_stall(urs, rs, trs) || m_src_stall(urt, rt, trt));
            exp_dr = m_fwd(rs, 0, 2, 1);
            exp_dt = m_fwd(rt, 0, 2, 1);
            exp_er = m_fwd(pipe[0].rs, 1, 1, 2);
            exp_et = m_fwd(pipe[0].rt, 1, 1, 2);
            n_checks++; if (hz.stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d want %0d", cyc, hz.stall, exp_stall); end
            n_checks++; if (hz.fwd_d_rs !== 2'(exp_dr)) begin n_fail++; $display("FAIL rnd_fwd_d_rs c%0d: got %0d want %0d", cyc, hz.fwd_d_rs, exp_dr); end
            n_checks++; if (hz.fwd_d_rt !== 2'(exp_dt)) begin n_fail++; $display("FAIL rnd_fwd_d_rt c%0d: got %0d want %0d", cyc, hz.fwd_d_rt, exp_dt); end
            n_checks++; if (hz.fwd_e_rs !== 2'(exp_er)) begin n_fail++; $display("FAIL rnd_fwd_e_rs c%0d: got %0d want %0d", cyc, hz.fwd_e_rs, exp_er); end
            n_checks++; if (hz.fwd_e_rt !== 2'(exp_et)) begin n_fail++; $display("FAIL rnd_fwd_e_rt c%0d: got %0d want %0d", cyc, hz.fwd_e_rt, exp_et); end
            n_checks++; if (hz.rf_we !== (pipe[2].valid && pipe[2].dst != 0)) begin
                n_fail++; $display("FAIL rnd_rf_we c%0d: got %0d want %0d", cyc, hz.rf_we, pipe[2].valid && pipe[2].dst != 0); end
            n_checks++; if (hz.rf_a3 !== 5'(pipe[2].dst)) begin n_fail++; $display("FAIL rnd_rf_a3 c%0d: got %0d want %0d", cyc, hz.rf_a3, pipe[2].dst); end
            n_checks++; if (hz.stall_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, hz.stall_cnt, m_cnt); end
            if (rst_now) reset = 1'b1;
            @(posedge clk);
            if (rst_now) begin
                model_clear();
            end else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (exp_stall) pipe[0] = '{valid: 0, dst: 0, ready: 0, rs: 0, rt: 0};
                else           pipe[0] = '{valid: v, dst: dst, ready: now + 1 + tnew, rs: rs, rt: rt};
                now++;
                if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end
            #1;
            reset = 1'b0;
            hold  = !rst_now && exp_stall;
        end
    endtask

    initial begin
        reset = 1'b1;
        nop();
        test_reset();
        test_load_use();
        test_alu_branch();
        test_jal_jr();
        test_reg_zero();
        test_back_to_back();
        test_reset_in_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
